// File: rtl/seg7_scan_pkg.sv
// Shared types and constants for the multiplexed seven-segment scanner.
package seg7_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  // Register stages before the edge-detect delay stage.
  localparam int unsigned SYNC_DEPTH = 2;

  // Active-high {g,f,e,d,c,b,a} patterns for hex digits 0..F.
  localparam logic [6:0] SEG_PATTERNS [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-high segment pattern.
module seg7_decode
  import seg7_scan_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SEG_PATTERNS[nibble];
  end

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed seven-segment driver stepped by a synchronised divided clock,
// with guard blanking, per-frame value latch and leading-zero blanking.
module seg7_scan
  import seg7_scan_pkg::*;
#(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned GUARD      = 2,
  parameter bit          BLANK_LZ   = 1'b1,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic                  scan_clk,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  output logic [6:0]            seg,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int unsigned IW = $clog2(DIGITS);
  localparam int unsigned CW = (GUARD > 1) ? $clog2(GUARD) : 1;
  localparam logic [IW-1:0]     LAST    = IW'(DIGITS - 1);
  localparam logic [6:0]        SEG_OFF = {7{ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{ACTIVE_LOW}};

  state_t                state;
  logic [SYNC_DEPTH:0]   sync;
  logic                  step;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [4*DIGITS-1:0]   shadow;
  logic [DIGITS-1:0]     dp_sh;

  logic                  wrap;
  logic [IW-1:0]         next_idx;
  logic [4*DIGITS-1:0]   next_shadow;
  logic [DIGITS-1:0]     next_dp;
  logic [3:0]            nibble;
  logic [6:0]            pattern;
  logic [DIGITS-1:0]     onehot;
  logic                  zero_run;
  logic                  lz;

  // Display values are computed from the post-advance index and frame so the
  // outputs can be registered on the same edge that enters DRIVE.
  always_comb begin
    wrap        = (idx == LAST);
    next_idx    = wrap ? '0 : idx + 1'b1;
    next_shadow = wrap ? value : shadow;
    next_dp     = wrap ? dp : dp_sh;
    nibble      = next_shadow[4*next_idx +: 4];
    onehot      = '0;
    onehot[next_idx] = 1'b1;
    zero_run    = 1'b1;
    lz          = 1'b0;
    for (int unsigned i = DIGITS - 1; i > 0; i--) begin
      zero_run = zero_run & (next_shadow[4*i +: 4] == 4'h0);
      if (BLANK_LZ && (i == 32'(next_idx))) lz = zero_run;
    end
  end

  seg7_decode u_decode (
    .nibble  (nibble),
    .pattern (pattern)
  );

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      sync       <= '0;
      step       <= 1'b0;
      state      <= IDLE;
      cnt        <= '0;
      idx        <= LAST;
      shadow     <= '0;
      dp_sh      <= '0;
      an         <= AN_OFF;
      seg        <= SEG_OFF;
      dp_out     <= ACTIVE_LOW;
      frame_done <= 1'b0;
    end else begin
      sync       <= {sync[SYNC_DEPTH-1:0], scan_clk};
      step       <= sync[SYNC_DEPTH-1] & ~sync[SYNC_DEPTH];
      frame_done <= 1'b0;
      case (state)
        IDLE, DRIVE: begin
          if (step) begin
            state  <= BLANK;
            cnt    <= '0;
            an     <= AN_OFF;
            seg    <= SEG_OFF;
            dp_out <= ACTIVE_LOW;
          end
        end
        BLANK: begin
          // Steps seen here are intentionally ignored.
          if (cnt == CW'(GUARD - 1)) begin
            state      <= DRIVE;
            idx        <= next_idx;
            shadow     <= next_shadow;
            dp_sh      <= next_dp;
            an         <= onehot ^ AN_OFF;
            seg        <= lz ? SEG_OFF : (pattern ^ SEG_OFF);
            dp_out     <= next_dp[next_idx] ^ ACTIVE_LOW;
            frame_done <= (next_idx == LAST);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
